// File: rtl/instr_fetch_unit.sv
// PC register and one-entry instruction register feeding decode, with branch/jump/jr redirects.
// Optional FETCH_ALIGN_CHECK_EN: sticky fetch_fault on a jr target whose low two bits are nonzero.
//
// state | meaning
// EMPTY | IR holds nothing consumable (instr_valid = 0)
// FULL  | IR holds an instruction waiting for decode (instr_valid = 1)
module instr_fetch_unit #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  input  logic                  fetch_en,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [31:0]           instr_pc,
  output logic [31:0]           instr_pc4,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [1:0]            redirect_kind,
  input  logic [15:0]           br_imm,
  input  logic [25:0]           j_index,
  input  logic [31:0]           jr_target,
  output logic                  fetch_fault
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JUMP   = 2'b01;
  localparam logic [1:0] KIND_JR     = 2'b10;
  localparam logic [1:0] KIND_NONE   = 2'b11;

  state_t                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           ipc_q, ipc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;

  logic        accept;
  logic        load;
  logic        take;
  logic [31:0] target;

  assign instr       = ir_q;
  assign instr_pc    = ipc_q;
  assign instr_pc4   = ipc_q + 32'd4;
  assign instr_valid = (state_q == FULL);
  assign rom_addr    = pc_q[ADDR_WIDTH+1:2];

  assign accept = instr_valid & instr_ready;
  assign load   = fetch_en & (~instr_valid | instr_ready);
  assign take   = accept & redirect & (redirect_kind != KIND_NONE);

  // Targets are always word aligned; jr silently drops its low two bits.
  always_comb begin
    target = jr_target & 32'hFFFF_FFFC;
    case (redirect_kind)
      KIND_BRANCH: target = instr_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
      KIND_JUMP:   target = {instr_pc4[31:28], j_index, 2'b00};
      default:     target = jr_target & 32'hFFFF_FFFC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      pc_q    <= RESET_PC;
      ipc_q   <= 32'd0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      ir_q    <= ir_d;
    end
  end

  // A taken redirect wins over a load so the sequential word is squashed.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    ir_d    = ir_q;
    if (take) begin
      pc_d    = target;
      state_d = EMPTY;
    end else if (load) begin
      ir_d    = rom_q;
      ipc_d   = pc_q;
      pc_d    = pc_q + 32'd4;
      state_d = FULL;
    end else if (accept) begin
      state_d = EMPTY;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  logic fault_d;

  always_comb begin
    fault_d = fault_q;
    if (take && (redirect_kind == KIND_JR) && (jr_target[1:0] != 2'b00))
      fault_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic
// compared against a transaction-level reference model of the fetch stage.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] WORD_A = 32'hA000_00AA;
  localparam logic [31:0] WORD_B = 32'hB000_00BB;
  localparam logic [31:0] WORD_C = 32'hC000_00CC;
  localparam logic [31:0] WORD_D = 32'hD000_00DD;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rom_addr;
  logic [31:0] rom_q;
  logic        fetch_en;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [1:0]  redirect_kind;
  logic [15:0] br_imm;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic        fetch_fault;

  logic [31:0] rom [256];

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc, m_ir, m_ipc;
  logic        m_valid, m_fault;

  always #5 clk = ~clk;

  assign rom_q = rom[rom_addr];

  instr_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .fetch_en     (fetch_en),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_pc4    (instr_pc4),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_kind(redirect_kind),
    .br_imm       (br_imm),
    .j_index      (j_index),
    .jr_target    (jr_target),
    .fetch_fault  (fetch_fault)
  );

  // Model one clock: decide what happens to the pending instruction, then to the next fetch.
  task automatic tick();
    logic [31:0] link;
    logic [31:0] dest;
    bit          consumed;
    consumed = m_valid && instr_ready;
    link     = m_ipc + 32'd4;
    if (consumed && redirect && redirect_kind != 2'd3) begin
      if (redirect_kind == 2'd0)
        dest = link + 32'(signed'(br_imm)) * 32'd4;
      else if (redirect_kind == 2'd1)
        dest = (link & 32'hF000_0000) + {4'h0, j_index, 2'b00};
      else begin
        dest = jr_target - 32'(jr_target % 4);
        if (ALIGN_CHECK && (jr_target % 4) != 0) m_fault = 1'b1;
      end
      m_pc    = dest;
      m_valid = 1'b0;
    end else if (fetch_en && (!m_valid || instr_ready)) begin
      m_ir    = rom[(m_pc / 4) % 256];
      m_ipc   = m_pc;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
    end else if (consumed) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_en      = 1'b1;
    instr_ready   = 1'b1;
    redirect      = 1'b0;
    redirect_kind = 2'd0;
    br_imm        = 16'h0;
    j_index       = 26'h0;
    jr_target     = 32'h0;
  endtask

  task automatic do_reset(input logic en);
    idle_inputs();
    fetch_en = en;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_pc    = RST_PC;
    m_ir    = 32'h0;
    m_ipc   = 32'h0;
    m_valid = 1'b0;
    m_fault = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #3;
    checks++;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", instr_valid); end
    checks++;
    if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h want=0", instr); end
    checks++;
    if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc got=%h want=0", instr_pc); end
    checks++;
    if (instr_pc4 !== 32'h4) begin failures++; $display("FAIL reset_instr_pc4 got=%h want=4", instr_pc4); end
    checks++;
    if (rom_addr !== 8'h00) begin failures++; $display("FAIL reset_rom_addr got=%h want=00", rom_addr); end
    checks++;
    if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0b want=0", fetch_fault); end
  endtask

  task automatic test_sequential();
    logic [31:0] words [4];
    words = '{WORD_A, WORD_B, WORD_C, WORD_D};
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== words[i]) begin
        failures++;
        $display("FAIL seq_instr[%0d] got=%h valid=%0b want=%h", i, instr, instr_valid, words[i]);
      end
      checks++;
      if (instr_pc !== RST_PC + 32'(4 * i) || instr_pc4 !== RST_PC + 32'(4 * i + 4)) begin
        failures++;
        $display("FAIL seq_pc[%0d] got=%h/%h want=%h", i, instr_pc, instr_pc4, RST_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b1);
    tick();
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== WORD_B || rom_addr !== 8'h02) begin
        failures++;
        $display("FAIL stall_hold[%0d] got instr=%h addr=%h want=%h addr=02", i, instr, rom_addr, WORD_B);
      end
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (instr !== WORD_C || instr_pc !== 32'h0040_0008) begin
      failures++;
      $display("FAIL stall_release got=%h pc=%h want=%h pc=00400008", instr, instr_pc, WORD_C);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    tick();
    tick();
    tick();
    checks++;
    if (instr_pc !== 32'h0040_0008) begin failures++; $display("FAIL redir_setup got=%h want=00400008", instr_pc); end
    redirect = 1'b1; redirect_kind = 2'd0; br_imm = 16'hFFFE;
    tick();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL branch_bubble got=%0b want=0", instr_valid); end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0040_0004 || instr !== WORD_B) begin
      failures++;
      $display("FAIL branch_target got pc=%h instr=%h want pc=00400004", instr_pc, instr);
    end
    redirect = 1'b1; redirect_kind = 2'd1; j_index = 26'h010_0010;
    tick();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL jump_bubble got=%0b want=0", instr_valid); end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0040_0040 || instr !== rom[16]) begin
      failures++;
      $display("FAIL jump_target got pc=%h instr=%h want pc=00400040 instr=%h", instr_pc, instr, rom[16]);
    end
    redirect = 1'b1; redirect_kind = 2'd2; jr_target = 32'h0040_000E;
    tick();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || fetch_fault !== ALIGN_CHECK) begin
      failures++;
      $display("FAIL jr_bubble got valid=%0b fault=%0b want valid=0 fault=%0b", instr_valid, fetch_fault, ALIGN_CHECK);
    end
    tick();
    checks++;
    if (instr_pc !== 32'h0040_000C || instr !== WORD_D) begin
      failures++;
      $display("FAIL jr_target got pc=%h instr=%h want pc=0040000C instr=%h", instr_pc, instr, WORD_D);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (fetch_fault !== ALIGN_CHECK) begin
      failures++;
      $display("FAIL fault_sticky got=%0b want=%0b", fetch_fault, ALIGN_CHECK);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || rom_addr !== 8'h00 || instr !== 32'h0 || fetch_fault !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got valid=%0b addr=%h instr=%h fault=%0b want 0/00/0/0",
               instr_valid, rom_addr, instr, fetch_fault);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_fetch_disable();
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b0 || rom_addr !== 8'h00) begin
        failures++;
        $display("FAIL fetch_off[%0d] got valid=%0b addr=%h want 0/00", i, instr_valid, rom_addr);
      end
    end
    fetch_en = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== WORD_A) begin
      failures++;
      $display("FAIL fetch_on got valid=%0b instr=%h want %h", instr_valid, instr, WORD_A);
    end
  endtask

  task automatic test_ignored_redirect();
    do_reset(1'b1);
    tick();
    instr_ready = 1'b0; redirect = 1'b1; redirect_kind = 2'd1; j_index = 26'h3FF_FFFF;
    tick();
    checks++;
    if (instr !== WORD_A || instr_valid !== 1'b1 || rom_addr !== 8'h01) begin
      failures++;
      $display("FAIL redir_no_ready got instr=%h addr=%h want %h addr=01", instr, rom_addr, WORD_A);
    end
    instr_ready = 1'b1; redirect_kind = 2'd3;
    tick();
    checks++;
    if (instr !== WORD_B || instr_pc !== 32'h0040_0004 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL redir_kind11 got instr=%h pc=%h want %h pc=00400004", instr, instr_pc, WORD_B);
    end
    redirect = 1'b0;
  endtask

  task automatic test_random();
    do_reset(1'b1);
    for (int n = 0; n < 600; n++) begin
      fetch_en      = ($urandom_range(0, 9) != 0);
      instr_ready   = ($urandom_range(0, 3) != 0);
      redirect      = ($urandom_range(0, 4) == 0);
      redirect_kind = 2'($urandom_range(0, 3));
      br_imm        = 16'($urandom);
      j_index       = 26'($urandom);
      jr_target     = $urandom;
      tick();
      checks++;
      if (instr_valid !== m_valid) begin
        failures++;
        $display("FAIL rnd_valid[%0d] got=%0b want=%0b", n, instr_valid, m_valid);
      end
      checks++;
      if (instr !== m_ir || instr_pc !== m_ipc || instr_pc4 !== m_ipc + 32'd4) begin
        failures++;
        $display("FAIL rnd_ir[%0d] got=%h@%h want=%h@%h", n, instr, instr_pc, m_ir, m_ipc);
      end
      checks++;
      if (rom_addr !== m_pc[9:2]) begin
        failures++;
        $display("FAIL rnd_rom_addr[%0d] got=%h want=%h", n, rom_addr, m_pc[9:2]);
      end
      checks++;
      if (fetch_fault !== m_fault) begin
        failures++;
        $display("FAIL rnd_fault[%0d] got=%0b want=%0b", n, fetch_fault, m_fault);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = WORD_A;
    rom[1] = WORD_B;
    rom[2] = WORD_C;
    rom[3] = WORD_D;
    reset = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_fetch_disable();
    test_ignored_redirect();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
